// File: rtl/mmio_timer_uartrx_if.sv
`timescale 1ns/1ps
// Purpose : core-side load/store bus between the MIPS core and mmio_timer_uartrx.
// Signals : rd/wr strobes (pre-qualified with addr[30]), byte address, store data, read data.
// Timing  : read data is combinational in the same cycle; writes land on the next clock edge.
interface mmio_timer_uartrx_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, wr, addr, wdata, input rdata);
  modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/mmio_timer_uartrx.sv
`timescale 1ns/1ps
// Purpose : peripheral responder with a reloadable 32-bit interval timer and an 8N1 UART receiver.
// Ports   : clk/reset (sync, active-high), bus (slave modport: rd/wr/addr/wdata -> rdata), rx serial in, irq out.
// Timing  : rdata combinational in the read cycle; writes take effect at the edge; irq registered (+1 cycle).
module mmio_timer_uartrx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_timer_uartrx_if.slave   bus,
  input  logic                 rx,
  output logic                 irq
);

  localparam int          CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Only the low byte of the address is decoded; the core already qualified the window.
  logic unused_bits;
  assign unused_bits = ^{bus.addr[31:8], bus.addr[1:0], BASE_ADDR};

  logic [7:0] off;
  assign off = {bus.addr[7:2], 2'b00};

  logic wr_th, wr_tl, wr_tcon, wr_ucon, rd_rxd;
  assign wr_th   = bus.wr && (off == 8'h00);
  assign wr_tl   = bus.wr && (off == 8'h04);
  assign wr_tcon = bus.wr && (off == 8'h08);
  assign wr_ucon = bus.wr && (off == 8'h20);
  assign rd_rxd  = bus.rd && (off == 8'h18);

  logic [31:0]   th_q, th_d, tl_q, tl_d;
  logic [2:0]    tcon_q, tcon_d;
  logic [7:0]    rxd_q, rxd_d, shift_q, shift_d;
  logic          rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d, rx_ie_q, rx_ie_d;
  logic          irq_q, irq_d;
  logic          rs1_q, rs2_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          rx_done, rx_stop_ok, timer_ovf;

  // Receiver FSM, driven by the synchronized line rs2_q.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    rx_done    = 1'b0;
    rx_stop_ok = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rs2_q) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        // Re-check the line half a bit in; a high level here was a glitch.
        if (cnt_q == CNT_HALF) begin
          if (rs2_q) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rs2_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          rx_done    = 1'b1;
          rx_stop_ok = rs2_q;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register next-state: CPU writes first, hardware events layered on top where they must win.
  always_comb begin
    timer_ovf   = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
    th_d        = th_q;
    tl_d        = tl_q;
    tcon_d      = tcon_q;
    rxd_d       = rxd_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    rx_ie_d     = rx_ie_q;

    if (tcon_q[0]) tl_d = timer_ovf ? th_q : tl_q + 32'd1;
    if (wr_th)     th_d = bus.wdata;
    if (wr_tl)     tl_d = bus.wdata;
    if (wr_tcon)   tcon_d = {tcon_q[2] & bus.wdata[2], bus.wdata[1:0]};
    if (timer_ovf && tcon_q[1]) tcon_d[2] = 1'b1;

    if (rd_rxd) rx_valid_d = 1'b0;
    if (wr_ucon) begin
      overrun_d   = overrun_q & ~bus.wdata[1];
      frame_err_d = frame_err_q & ~bus.wdata[2];
      rx_ie_d     = bus.wdata[3];
    end
    if (rx_done) begin
      if (rx_stop_ok) begin
        rxd_d      = shift_q;
        rx_valid_d = 1'b1;
        if (rx_valid_q) overrun_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
      end
    end

    irq_d = tcon_q[2] | (rx_valid_q & rx_ie_q);
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      case (off)
        8'h00:   bus.rdata = th_q;
        8'h04:   bus.rdata = tl_q;
        8'h08:   bus.rdata = {29'd0, tcon_q};
        8'h18:   bus.rdata = {24'd0, rxd_q};
        8'h20:   bus.rdata = {28'd0, rx_ie_q, frame_err_q, overrun_q, rx_valid_q};
        default: bus.rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q        <= '0;
      tl_q        <= '0;
      tcon_q      <= '0;
      rxd_q       <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_ie_q     <= 1'b0;
      irq_q       <= 1'b0;
      rs1_q       <= 1'b1;
      rs2_q       <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
    end else begin
      th_q        <= th_d;
      tl_q        <= tl_d;
      tcon_q      <= tcon_d;
      rxd_q       <= rxd_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rx_ie_q     <= rx_ie_d;
      irq_q       <= irq_d;
      rs1_q       <= rx;
      rs2_q       <= rs1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_mmio_timer_uartrx.sv
`timescale 1ns/1ps
module tb_mmio_timer_uartrx;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic irq;

  mmio_timer_uartrx_if bus_if ();

  mmio_timer_uartrx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .rx    (rx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit tx_done = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_th, m_tl;
  logic [2:0]  m_tcon;
  logic [7:0]  m_rxd;
  logic        m_rxv, m_ovr, m_fe, m_ie, m_irq;
  int          cyc = 0;
  // A frame handed to the line is known to land at a fixed edge after its start bit.
  bit          pend_vld = 1'b0;
  int          pend_cyc;
  logic [7:0]  pend_byte;
  logic        pend_stop;

  always @(posedge clk) begin : model
    logic [7:0]  o;
    logic        ovf;
    logic [31:0] n_th, n_tl;
    logic [2:0]  n_tcon;
    logic [7:0]  n_rxd;
    logic        n_rxv, n_ovr, n_fe, n_ie, n_irq;
    if (reset) begin
      m_th = 0; m_tl = 0; m_tcon = 0; m_rxd = 0;
      m_rxv = 0; m_ovr = 0; m_fe = 0; m_ie = 0; m_irq = 0;
      pend_vld = 1'b0;
    end else begin
      o      = bus_if.addr[7:0] & 8'hFC;
      n_irq  = m_tcon[2] | (m_rxv & m_ie);
      ovf    = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
      n_th   = m_th;
      n_tl   = m_tcon[0] ? (ovf ? m_th : m_tl + 1) : m_tl;
      n_tcon = m_tcon;
      if (bus_if.wr && o == 8'h00) n_th = bus_if.wdata;
      if (bus_if.wr && o == 8'h04) n_tl = bus_if.wdata;
      if (bus_if.wr && o == 8'h08) n_tcon = {m_tcon[2] & bus_if.wdata[2], bus_if.wdata[1:0]};
      if (ovf && m_tcon[1]) n_tcon[2] = 1'b1;
      n_rxd = m_rxd; n_rxv = m_rxv; n_ovr = m_ovr; n_fe = m_fe; n_ie = m_ie;
      if (bus_if.rd && o == 8'h18) n_rxv = 1'b0;
      if (bus_if.wr && o == 8'h20) begin
        n_ovr = m_ovr & ~bus_if.wdata[1];
        n_fe  = m_fe  & ~bus_if.wdata[2];
        n_ie  = bus_if.wdata[3];
      end
      if (pend_vld && cyc == pend_cyc) begin
        pend_vld = 1'b0;
        if (pend_stop) begin
          n_rxd = pend_byte; n_rxv = 1'b1;
          if (m_rxv) n_ovr = 1'b1;
        end else begin
          n_fe = 1'b1;
        end
      end
      m_th = n_th; m_tl = n_tl; m_tcon = n_tcon; m_rxd = n_rxd;
      m_rxv = n_rxv; m_ovr = n_ovr; m_fe = n_fe; m_ie = n_ie; m_irq = n_irq;
    end
    cyc++;
  end

  function automatic logic [31:0] m_read();
    logic [7:0] o;
    o = bus_if.addr[7:0] & 8'hFC;
    if (!bus_if.rd) return 32'd0;
    case (o)
      8'h00:   return m_th;
      8'h04:   return m_tl;
      8'h08:   return {29'd0, m_tcon};
      8'h18:   return {24'd0, m_rxd};
      8'h20:   return {28'd0, m_ie, m_fe, m_ovr, m_rxv};
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("rdata_vs_model", bus_if.rdata, m_read());
      check("irq_vs_model", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  // ---------------- stimulus helpers (entered #1 after a rising edge) ----------------
  task automatic bus_write(input logic [7:0] o, input logic [31:0] d);
    bus_if.wr = 1'b1; bus_if.addr = 32'h4000_0000 | {24'd0, o}; bus_if.wdata = d;
    @(posedge clk); #1;
    bus_if.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] o, output logic [31:0] d);
    bus_if.rd = 1'b1; bus_if.addr = 32'h4000_0000 | {24'd0, o};
    @(negedge clk);
    d = bus_if.rdata;
    @(posedge clk); #1;
    bus_if.rd = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [7:0] o, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(o, d);
    check(name, d, exp);
  endtask

  task automatic hold_bit();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_ok, input int idle_bits);
    @(posedge clk); #1;
    // Start bit driven after edge cyc-1; two sync stages, one edge to leave IDLE,
    // half a bit of start, eight data bits and the stop bit.
    pend_byte = b; pend_stop = stop_ok;
    pend_cyc  = cyc + 2 + CPB / 2 + 9 * CPB;
    pend_vld  = 1'b1;
    rx = 1'b0; hold_bit();
    for (int i = 0; i < 8; i++) begin rx = b[i]; hold_bit(); end
    rx = stop_ok; hold_bit();
    rx = 1'b1;
    repeat (idle_bits) hold_bit();
  endtask

  function automatic logic [7:0] pick_off(input int k);
    case (k)
      0: return 8'h00; 1: return 8'h04; 2: return 8'h08; 3: return 8'h0C;
      4: return 8'h18; 5: return 8'h1C; 6: return 8'h20; default: return 8'h24;
    endcase
  endfunction

  initial begin
    bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    rx = 1'b1; reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state
    read_chk("rst_th", 8'h00, 32'h0);
    read_chk("rst_tl", 8'h04, 32'h0);
    read_chk("rst_tcon", 8'h08, 32'h0);
    read_chk("rst_rxd", 8'h18, 32'h0);
    read_chk("rst_ucon", 8'h20, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);

    // Timer reload and overflow status
    bus_write(8'h00, 32'hFFFF_FFFD);
    bus_write(8'h04, 32'hFFFF_FFFE);
    bus_write(8'h08, 32'h3);
    read_chk("tl_seq0", 8'h04, 32'hFFFF_FFFE);
    read_chk("tl_seq1", 8'h04, 32'hFFFF_FFFF);
    read_chk("tl_seq2", 8'h04, 32'hFFFF_FFFD);
    check("tmr_irq_set", {31'd0, irq}, 32'h1);
    read_chk("tcon_status", 8'h08, 32'h7);
    bus_write(8'h08, 32'h3);            // lands on an overflow edge: status stays set
    bus_write(8'h08, 32'h3);            // clears status
    read_chk("tcon_cleared", 8'h08, 32'h3);
    check("tmr_irq_drop", {31'd0, irq}, 32'h0);
    bus_write(8'h08, 32'h0);
    bus_write(8'h08, 32'h0);
    repeat (3) @(posedge clk); #1;
    check("tmr_idle_irq", {31'd0, irq}, 32'h0);

    // UART single byte
    bus_write(8'h20, 32'h8);
    send(8'hA5, 1'b1, 2);
    check("rx_irq_set", {31'd0, irq}, 32'h1);
    read_chk("ucon_valid", 8'h20, 32'h9);
    read_chk("rxd_a5", 8'h18, 32'hA5);
    read_chk("ucon_after_rd", 8'h20, 32'h8);
    check("rx_irq_clr", {31'd0, irq}, 32'h0);

    // Overrun
    send(8'h3C, 1'b1, 1);
    send(8'hC3, 1'b1, 1);
    read_chk("ucon_overrun", 8'h20, 32'hB);
    bus_write(8'h20, 32'hA);
    read_chk("ucon_ovr_clr", 8'h20, 32'h9);
    read_chk("rxd_c3", 8'h18, 32'hC3);

    // Framing error and glitch
    send(8'h5A, 1'b0, 2);
    read_chk("ucon_frame_err", 8'h20, 32'hC);
    read_chk("rxd_kept", 8'h18, 32'hC3);
    bus_write(8'h20, 32'hC);
    read_chk("ucon_fe_clr", 8'h20, 32'h8);
    rx = 1'b0; @(posedge clk); @(posedge clk); #1; rx = 1'b1;
    repeat (3 * CPB) @(posedge clk); #1;
    read_chk("ucon_glitch", 8'h20, 32'h8);

    // Reset in the middle of a frame
    bus_write(8'h00, 32'h1234_5678);
    bus_write(8'h08, 32'h1);
    rx = 1'b0; hold_bit();
    rx = 1'b1; hold_bit();
    rx = 1'b0; hold_bit();
    reset = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    read_chk("mid_rst_th", 8'h00, 32'h0);
    read_chk("mid_rst_tl", 8'h04, 32'h0);
    read_chk("mid_rst_tcon", 8'h08, 32'h0);
    read_chk("mid_rst_rxd", 8'h18, 32'h0);
    read_chk("mid_rst_ucon", 8'h20, 32'h0);
    bus_write(8'h20, 32'h8);
    send(8'h55, 1'b1, 2);
    read_chk("ucon_55", 8'h20, 32'h9);
    read_chk("rxd_55", 8'h18, 32'h55);

    // Randomized traffic: frames on the line while the bus pokes every register
    fork
      begin
        for (int f = 0; f < 8; f++)
          send(8'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(1, 3));
        tx_done = 1'b1;
      end
      begin
        while (!tx_done) begin
          int op;
          logic [7:0] o;
          op = $urandom_range(0, 9);
          o  = pick_off($urandom_range(0, 7)) | 8'($urandom_range(0, 3));
          bus_if.addr = {$urandom} | 32'h4000_0000;
          bus_if.addr[7:0] = o;
          if (op >= 5 && op <= 7) begin
            bus_if.rd = 1'b1;
          end else if (op >= 8) begin
            bus_if.wr = 1'b1;
            case (o & 8'hFC)
              8'h00, 8'h04: bus_if.wdata = ($urandom_range(0, 3) == 0) ? $urandom
                                          : (32'hFFFF_FFF0 | $urandom_range(0, 15));
              default:      bus_if.wdata = $urandom;
            endcase
          end
          @(posedge clk); #1;
          bus_if.rd = 1'b0; bus_if.wr = 1'b0;
        end
      end
    join

    repeat (4) @(posedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_timer_uartrx.md
Name: mmio_timer_uartrx

Overview:
- Memory-mapped bus responder for the single-cycle MIPS core; answers core loads/stores in the peripheral window (addr[30]=1).
- Contains a reloadable 32-bit interval timer and an 8N1 UART receiver.
- Drives the core's IRQ line from timer overflow and UART receive-ready.
- The core supplies qualified rd/wr strobes, the byte address and write data; this block returns combinational read data within the same cycle.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 4.
- BASE_ADDR, 32'h40000000, peripheral window base; only addr[7:0] is decoded.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd  in  1  read strobe, already qualified by the core with addr[30].
- wr  in  1  write strobe, already qualified by the core with addr[30].
- addr  in  32  byte address; addr[1:0] ignored.
- wdata  in  32  store data.
- rdata  out  32  combinational read data; 0 when rd=0 or the offset is unmapped.
- rx  in  1  asynchronous serial input, idle high.
- irq  out  1  interrupt request to the core.

Behaviour:
Register map (offset = addr[7:0]):
- 0x00 TH: reload value, R/W.
- 0x04 TL: counter, R/W.
- 0x08 TCON, R/W. bit0 = timer enable; bit1 = timer irq enable; bit2 = timer irq status, W0C (writing 0 clears it, writing 1 has no effect).
- 0x18 RXD, RO. [7:0] = last received byte; reading it clears rx_valid on that clock edge.
- 0x20 UCON: bit0 rx_valid (RO), bit1 overrun (W1C), bit2 frame_err (W1C), bit3 rx irq enable (R/W). Upper bits read 0.

Reset:
- TH, TL, TCON, RXD and UCON all 0.
- irq = 0; receiver in IDLE.
- The rx synchronizer flops reset to 1.
- A reset asserted mid-frame discards the partial byte.

Timer (when TCON.bit0 = 1), every cycle:
- If TL = 32'hFFFFFFFF: TL <= TH, and if TCON.bit1 = 1 then TCON.bit2 <= 1.
- Otherwise TL <= TL + 1.
- A CPU write to TL in the same cycle wins over increment/reload.
- A CPU write to TCON that leaves bit2 = 1 while overflow occurs: bit2 ends at 1.
- Status set by overflow beats a same-cycle W0C clear.

UART receiver:
- rx passes through a 2-flop synchronizer (rs) before use.
- State machine IDLE -> START -> DATA -> STOP -> IDLE, with a bit counter (0..CLKS_PER_BIT-1) and a 3-bit bit index.
- IDLE: on rs = 0, clear the counter and go to START.
- START: at counter = CLKS_PER_BIT/2 - 1, sample rs. If 1 (glitch), return to IDLE; else clear the counter and go to DATA.
- DATA: every CLKS_PER_BIT cycles sample rs into shift[index] (LSB first). After index 7, go to STOP.
- STOP: after CLKS_PER_BIT cycles sample rs.
  - If 1: RXD <= shift; rx_valid <= 1; overrun <= 1 if rx_valid was already 1 (the new byte overwrites).
  - If 0: frame_err <= 1; RXD and rx_valid unchanged.
  - Return to IDLE either way.
- Completion in the same cycle as a CPU read of RXD: the read returns the old RXD, and rx_valid ends at 1 (set beats clear).

Bus rules:
- Writes take effect at the clock edge.
- Writes to RO or unmapped offsets are ignored.
- rd and wr are never both asserted.

irq (registered):
- Next value = TCON.bit2 | (UCON.bit0 & UCON.bit3).
- So irq follows the status bits one cycle later.

Test Plan:
- Reset, then read all 5 registers -> every read returns 0; irq = 0.
- Write TH = 32'hFFFFFFFD, TL = 32'hFFFFFFFE, TCON = 3 -> TL goes FFFFFFFF, FFFFFFFD, FFFFFFFE; TCON reads 7 after the overflow edge; irq = 1 one cycle later. Write TCON = 3 -> irq drops on the following cycle.
- CLKS_PER_BIT = 8; serially drive 0xA5 on rx (8N1) with UCON = 8 -> RXD = 0xA5, UCON = 9, irq = 1. Read RXD -> returns 0xA5; UCON then reads 8; irq = 0.
- Send 0x3C then 0xC3 without reading RXD -> RXD = 0xC3 and UCON.bit1 = 1. Write UCON = 0x0A -> overrun clears, enable stays set.
- Send a frame with stop bit = 0 -> frame_err = 1, rx_valid stays 0. A 2-cycle low glitch on rx -> receiver returns to IDLE with no flags set.
- Assert reset during DATA of a frame -> all registers 0. A subsequent clean frame with 0x55 is received correctly.
